// File: rtl/phase_accumulator.sv
// NCO phase generator: 28-bit FTW accumulator plus 12-bit phase offset, registered phase word.
// Optional PHASE_ACC_SEL_SYNC_EN adds 2-flop synchronizers on freq_sel/phase_sel.
module phase_accumulator #(
  parameter int ACC_W = 28,
  parameter int OUT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ACC_W-1:0] freq0_set,
  input  logic [ACC_W-1:0] freq1_set,
  input  logic             freq_sel,
  input  logic [OUT_W-1:0] phase0_set,
  input  logic [OUT_W-1:0] phase1_set,
  input  logic             phase_sel,
  output logic [OUT_W-1:0] phase_out
);

  logic             freq_sel_eff;
  logic             phase_sel_eff;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw;
  logic [OUT_W-1:0] poff;
  logic [ACC_W-1:0] acc_next;
  logic [OUT_W-1:0] phase_next;

`ifdef PHASE_ACC_SEL_SYNC_EN
  // Selects may come from another domain; data words are assumed quasi-static.
  logic [1:0] freq_sync;
  logic [1:0] phase_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      freq_sync  <= '0;
      phase_sync <= '0;
    end else begin
      freq_sync  <= {freq_sync[0], freq_sel};
      phase_sync <= {phase_sync[0], phase_sel};
    end
  end

  assign freq_sel_eff  = freq_sync[1];
  assign phase_sel_eff = phase_sync[1];
`else
  assign freq_sel_eff  = freq_sel;
  assign phase_sel_eff = phase_sel;
`endif

  always_comb begin
    ftw        = freq_sel_eff ? freq1_set : freq0_set;
    poff       = phase_sel_eff ? phase1_set : phase0_set;
    acc_next   = acc + ftw;
    // Output uses this edge's accumulation, so phase_out has no extra lag behind acc.
    phase_next = acc_next[ACC_W-1 -: OUT_W] + poff;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      phase_out <= '0;
    end else begin
      acc       <= acc_next;
      phase_out <= phase_next;
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed self-checking bench for phase_accumulator (reset, accumulation, wrap, freq/phase switching).
module tb_phase_accumulator;

  logic        clock;
  logic        reset;
  logic [27:0] freq0_set;
  logic [27:0] freq1_set;
  logic        freq_sel;
  logic [11:0] phase0_set;
  logic [11:0] phase1_set;
  logic        phase_sel;
  logic [11:0] phase_out;

  int n_cmp = 0;
  int n_err = 0;

  phase_accumulator #(.ACC_W(28), .OUT_W(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .freq0_set  (freq0_set),
    .freq1_set  (freq1_set),
    .freq_sel   (freq_sel),
    .phase0_set (phase0_set),
    .phase1_set (phase1_set),
    .phase_sel  (phase_sel),
    .phase_out  (phase_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse reset away from the clock edge; the next edge is edge 1.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    freq0_set = 28'h000A7C6; freq1_set = 28'h0; freq_sel = 1'b0;
    phase0_set = 12'h0; phase1_set = 12'h0; phase_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (phase_out !== 12'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got %0d want 0", i, phase_out);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (phase_out !== 12'd0 || dut.acc !== 28'd0) begin
      n_err++;
      $display("FAIL reset_async: got phase %0d acc %0d want 0 0", phase_out, dut.acc);
    end
    tick();
    #1;
    reset = 1'b1;
    tick();
    n_cmp++;
    if (dut.acc !== 28'd42950 || phase_out !== 12'd0) begin
      n_err++;
      $display("FAIL reset_restart: got acc %0d phase %0d want 42950 0", dut.acc, phase_out);
    end
  endtask

  task automatic test_accumulation();
    freq0_set = 28'h000A7C6; freq_sel = 1'b0; phase0_set = 12'h0; phase_sel = 1'b0;
    do_reset();
    for (int k = 1; k <= 6250; k++) begin
      tick();
      if (k == 1) begin
        n_cmp++;
        if (phase_out !== 12'd0) begin n_err++; $display("FAIL accum_e1: got %0d want 0", phase_out); end
      end
      if (k == 2) begin
        n_cmp++;
        if (phase_out !== 12'd1) begin n_err++; $display("FAIL accum_e2: got %0d want 1", phase_out); end
      end
      if (k == 100) begin
        n_cmp++;
        if (phase_out !== 12'd65) begin n_err++; $display("FAIL accum_e100: got %0d want 65", phase_out); end
      end
      if (k == 6250) begin
        n_cmp++;
        if (dut.acc !== 28'd2044 || phase_out !== 12'd0) begin
          n_err++;
          $display("FAIL accum_wrap6250: got acc %0d phase %0d want 2044 0", dut.acc, phase_out);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_p [4];
    exp_p[0] = 12'd2048; exp_p[1] = 12'd0; exp_p[2] = 12'd2048; exp_p[3] = 12'd0;
    freq0_set = 28'h8000000; freq_sel = 1'b0; phase0_set = 12'h0; phase_sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (phase_out !== exp_p[i]) begin
        n_err++;
        $display("FAIL wrap_e%0d: got %0d want %0d", i + 1, phase_out, exp_p[i]);
      end
    end
  endtask

`ifndef PHASE_ACC_SEL_SYNC_EN
  task automatic test_freq_switch();
    freq0_set = 28'h000A7C6; freq1_set = 28'h0014F8C; freq_sel = 1'b0;
    phase0_set = 12'h0; phase_sel = 1'b0;
    do_reset();
    for (int i = 0; i < 500; i++) tick();
    n_cmp++;
    if (dut.acc !== 28'd21475000 || phase_out !== 12'd327) begin
      n_err++;
      $display("FAIL fsw_pre: got acc %0d phase %0d want 21475000 327", dut.acc, phase_out);
    end
    freq_sel = 1'b1;
    tick();
    n_cmp++;
    if (dut.acc !== 28'd21560900 || phase_out !== 12'd328) begin
      n_err++;
      $display("FAIL fsw_e1: got acc %0d phase %0d want 21560900 328", dut.acc, phase_out);
    end
    for (int i = 0; i < 9; i++) tick();
    n_cmp++;
    if (dut.acc !== 28'd22334000 || phase_out !== 12'd340) begin
      n_err++;
      $display("FAIL fsw_e10: got acc %0d phase %0d want 22334000 340", dut.acc, phase_out);
    end
    freq_sel = 1'b0;
    tick();
    n_cmp++;
    if (dut.acc !== 28'd22376950) begin
      n_err++;
      $display("FAIL fsw_back: got acc %0d want 22376950", dut.acc);
    end
  endtask

  task automatic test_phase_offset();
    freq0_set = 28'h0; freq_sel = 1'b0; phase0_set = 12'h0; phase1_set = 12'h3FF; phase_sel = 1'b0;
    do_reset();
    tick();
    n_cmp++;
    if (phase_out !== 12'h000) begin n_err++; $display("FAIL poff_base: got %h want 000", phase_out); end
    phase_sel = 1'b1;
    tick();
    n_cmp++;
    if (phase_out !== 12'h3FF) begin n_err++; $display("FAIL poff_step: got %h want 3ff", phase_out); end
    freq0_set = 28'hE000000;
    do_reset();
    tick();
    n_cmp++;
    if (phase_out !== 12'h1FF) begin n_err++; $display("FAIL poff_wrap: got %h want 1ff", phase_out); end
    freq0_set = 28'h0;
    tick();
    n_cmp++;
    if (phase_out !== 12'h1FF || dut.acc !== 28'hE000000) begin
      n_err++;
      $display("FAIL poff_hold: got phase %h acc %h want 1ff e000000", phase_out, dut.acc);
    end
    phase_sel = 1'b0;
    tick();
    n_cmp++;
    if (phase_out !== 12'hE00 || dut.acc !== 28'hE000000) begin
      n_err++;
      $display("FAIL poff_back: got phase %h acc %h want e00 e000000", phase_out, dut.acc);
    end
  endtask
`else
  task automatic test_sel_sync();
    logic [27:0] exp_acc [3];
    exp_acc[0] = 28'd128850; exp_acc[1] = 28'd171800; exp_acc[2] = 28'd257700;
    freq0_set = 28'h000A7C6; freq1_set = 28'h0014F8C; freq_sel = 1'b0;
    phase0_set = 12'h0; phase_sel = 1'b0;
    do_reset();
    tick();
    tick();
    freq_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut.acc !== exp_acc[i]) begin
        n_err++;
        $display("FAIL sync_e%0d: got acc %0d want %0d", i + 1, dut.acc, exp_acc[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_accumulation();
    test_wrap();
`ifndef PHASE_ACC_SEL_SYNC_EN
    test_freq_switch();
    test_phase_offset();
`else
    test_sel_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
